storage_arbiter: RTL
====================

# storage_arbiter

Shares one `storage_controller` memory port between the scalar instruction-fetch port and the data (scalar/vector LSU) port. It performs round-robin arbitration and latches the winner's request. It holds the controller's request signals stable until `out_valid`, then inserts the mandatory idle cycle and returns the response to the winning requester. A watchdog turns a missing `out_valid` (for example, after programming mode is entered) into an error response instead of a hang.

## Interface
- `MEM_W`, 32, data bus width; byte-enable width is `MEM_W/8`
- `EXT_BASE`, 32'h0000_1000, addresses >= this go to external QSPI storage
- `TIMEOUT`, 1024, maximum BUSY cycles to wait for `mem_valid`; must be >= 2
- Ports:
- `clk` in 1 clock
- `rst` in 1 reset: synchronous, active-low
- `i_req` in 1 ifetch request; payload valid while high
- `i_addr` in 32 ifetch byte address; read-only port
- `i_gnt` out 1 ifetch request accepted this cycle (combinational)
- `i_rvalid` out 1 one-cycle ifetch response pulse
- `i_rdata` out MEM_W ifetch read data, valid with `i_rvalid`
- `i_err` out 1 timeout error, valid with `i_rvalid`
- `d_req`, `d_we` (1), `d_addr` (32), `d_wdata` (MEM_W), `d_be` (MEM_W/8) in: data request and payload
- `d_gnt`, `d_rvalid`, `d_rdata` (MEM_W), `d_err` out: as ifetch
- `mem_access`, `mem_we`, `mem_addr` (32), `mem_wdata` (MEM_W), `mem_be` (MEM_W/8), `mem_ext` out: to the controller's `memory_access`, `memory_is_writing`, `addr`, `d_in`, `mem_be`, `external_storage_access`
- `mem_rdata` in MEM_W controller `d_out`
- `mem_valid` in 1 controller `out_valid`
- `prog_mode` in 1 mirrors `set_programming_mode`; blocks new grants
- `busy` out 1 high in every state except IDLE

## Operation
- States: IDLE, BUSY, RESP.
- IDLE:
  - If `prog_mode` is 0 and any request is high, grant exactly one: `x_gnt`=1 combinationally.
  - Latch that requester's payload. Ifetch uses `we`=0, `be`=all ones, `wdata`=0.
  - `mem_ext` is latched as `addr >= EXT_BASE` (unsigned).
  - Reset `cnt`, record the owner, go to BUSY.
- Arbitration:
  - Single request: that request wins.
  - Both high: the port not granted last time wins.
  - `last` resets to DATA, so ifetch wins the first tie.
  - `last` updates on every grant.
- BUSY:
  - `mem_access`=1 and latched payload on `mem_*`, stable every cycle.
  - If `mem_valid`=1: capture `mem_rdata` (writes capture 0), set `err`=0, go to RESP.
  - Else if `cnt`==TIMEOUT-1: capture 0, set `err`=1, go to RESP.
  - Else increment `cnt`.
  - `mem_valid` wins over the timeout in the same cycle.
- RESP:
  - `mem_access`=0; this is the idle cycle the controller needs to leave its done state.
  - Owner's `x_rvalid`=1 with captured data and `err`; other port's `rvalid`=0.
  - Always go to IDLE.
- Requesters may drop or change `req` after `gnt`. The transaction always completes, and the response is issued even if `req` was dropped.
- `prog_mode` rising in BUSY does not abort; the transaction ends by `mem_valid` or timeout.
- `mem_valid` outside BUSY is ignored.

## Timing
- Reset (`rst`=0 at a clk edge):
  - State IDLE, `last`=DATA, `cnt`=0.
  - All `mem_*`=0, all `rvalid`/`err`/`rdata`=0, `busy`=0.
  - Reset mid-transaction drops the in-flight request with no response.
- `gnt` is combinational in IDLE and is the only combinational output. All `mem_*`, `rvalid`, `rdata`, `err` are registered.
- Cycle numbering from grant at cycle 0:
  - `mem_access` is high from cycle 1.
  - If `mem_valid` arrives at cycle k, `rvalid` is at k+1 and IDLE at k+2.
  - The earliest next grant is k+2.
- SRAM path (controller answers 1 cycle after access): `mem_valid`@2, `rvalid`@3, next `gnt`@4, so 4-cycle throughput.
- Timeout: with no `mem_valid`, `rvalid`+`err` at cycle TIMEOUT+1.

## Structure
- Package `storage_arb_pkg`:
  - `arb_state_e` {IDLE, BUSY, RESP}
  - `port_e` {PORT_IFETCH, PORT_DATA}
  - default `EXT_BASE` constant
- Sub-module `rr_pick2`: combinational 2-way round-robin picker (req[1:0], last → grant one-hot). Everything else lives in `storage_arbiter`.

## Test plan
- Ifetch read 0x0000_0040, controller model returns 0xDEAD_BEEF at cycle 2 → `i_rvalid`@3, `i_rdata`=0xDEAD_BEEF, `i_err`=0, `mem_ext`=0, `mem_be`=4'hF.
- Data write 0x0000_2000, `d_be`=4'b0011, wdata 0x1234_5678 → `mem_ext`=1, `mem_we`=1, payload stable every BUSY cycle while model delays `mem_valid` 20 cycles; `d_rdata`=0.
- Both `req` held high for 4 transactions after reset → grant order I, D, I, D; `mem_access`=0 in each RESP cycle.
- TIMEOUT=8, model never answers → `d_rvalid`=1 and `d_err`=1 at cycle 9, `mem_access` low at cycle 9, then IDLE.
- `prog_mode`=1 in IDLE with `i_req` high → no `gnt` for 10 cycles; clear `prog_mode` → `i_gnt` same cycle.
- `rst`=0 during BUSY → next cycle all outputs 0, no `rvalid`; next tie grants ifetch first.

Source files
------------

// File: rtl/storage_arb_pkg.sv
// Shared types and constants for the storage-controller port arbiter.
// Imported by storage_arbiter and its round-robin picker.
package storage_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    PORT_IFETCH = 1'b0,
    PORT_DATA   = 1'b1
  } port_e;

  localparam logic [31:0] DEFAULT_EXT_BASE = 32'h0000_1000;

  // Addresses at or above the base live in external QSPI storage.
  function automatic logic is_ext_addr(input logic [31:0] addr, input logic [31:0] base);
    return (addr >= base);
  endfunction

endpackage

// File: rtl/storage_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: bit 0 is ifetch, bit 1 is data.
// On a tie the port that did not win last time is chosen.
module rr_pick2
  import storage_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  port_e      i_last,
  output logic [1:0] o_grant
);

  // One-hot grant selection.
  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11: begin
        if (i_last == PORT_DATA) begin
          o_grant = 2'b01;
        end else begin
          o_grant = 2'b10;
        end
      end
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/storage_arbiter.sv
// Shares one storage_controller port between ifetch and data requesters.
// Holds the request until out_valid (or watchdog expiry), then idles one cycle while responding.
module storage_arbiter
  import storage_arb_pkg::*;
#(
  parameter int unsigned MEM_W    = 32,
  parameter logic [31:0] EXT_BASE = DEFAULT_EXT_BASE,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_req,
  input  logic [31:0]        i_addr,
  output logic               i_gnt,
  output logic               i_rvalid,
  output logic [MEM_W-1:0]   i_rdata,
  output logic               i_err,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [31:0]        d_addr,
  input  logic [MEM_W-1:0]   d_wdata,
  input  logic [MEM_W/8-1:0] d_be,
  output logic               d_gnt,
  output logic               d_rvalid,
  output logic [MEM_W-1:0]   d_rdata,
  output logic               d_err,
  output logic               mem_access,
  output logic               mem_we,
  output logic [31:0]        mem_addr,
  output logic [MEM_W-1:0]   mem_wdata,
  output logic [MEM_W/8-1:0] mem_be,
  output logic               mem_ext,
  input  logic [MEM_W-1:0]   mem_rdata,
  input  logic               mem_valid,
  input  logic               prog_mode,
  output logic               busy
);

  localparam int unsigned BE_W     = MEM_W / 8;
  localparam int unsigned CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e         r_state;
  arb_state_e         w_state_nxt;
  port_e              r_last;
  port_e              r_owner;
  logic [CNT_W-1:0]   r_cnt;

  logic               r_mem_access;
  logic               r_mem_we;
  logic [31:0]        r_mem_addr;
  logic [MEM_W-1:0]   r_mem_wdata;
  logic [BE_W-1:0]    r_mem_be;
  logic               r_mem_ext;

  logic               r_i_rvalid;
  logic               r_d_rvalid;
  logic [MEM_W-1:0]   r_i_rdata;
  logic [MEM_W-1:0]   r_d_rdata;
  logic               r_i_err;
  logic               r_d_err;

  logic [1:0]         w_pick;
  logic               w_arb_en;
  logic               w_start;
  logic               w_finish;
  logic               w_timeout;
  port_e              w_win;
  logic [31:0]        w_sel_addr;
  logic [MEM_W-1:0]   w_rdata_cap;
  logic               w_resp_i;
  logic               w_resp_d;

  rr_pick2 u_pick (
    .i_req   ({d_req, i_req}),
    .i_last  (r_last),
    .o_grant (w_pick)
  );

  assign w_arb_en   = (r_state == IDLE) && !prog_mode;
  assign i_gnt      = w_arb_en && w_pick[0];
  assign d_gnt      = w_arb_en && w_pick[1];
  assign w_win      = d_gnt ? PORT_DATA : PORT_IFETCH;
  assign w_sel_addr = d_gnt ? d_addr : i_addr;
  // Writes and timeouts return zero data regardless of what the bus shows.
  assign w_rdata_cap = (w_timeout || r_mem_we) ? {MEM_W{1'b0}} : mem_rdata;
  assign w_resp_i    = w_finish && (r_owner == PORT_IFETCH);
  assign w_resp_d    = w_finish && (r_owner == PORT_DATA);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and transaction strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_finish    = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_gnt || d_gnt) begin
          w_start     = 1'b1;
          w_state_nxt = BUSY;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (mem_valid) begin
          w_finish    = 1'b1;
          w_state_nxt = RESP;
        end else if (r_cnt == CNT_LAST) begin
          w_finish    = 1'b1;
          w_timeout   = 1'b1;
          w_state_nxt = RESP;
        end else begin
          w_state_nxt = BUSY;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Arbitration history, ownership and watchdog counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last  <= PORT_DATA;
      r_owner <= PORT_IFETCH;
      r_cnt   <= {CNT_W{1'b0}};
    end else if (w_start) begin
      r_last  <= w_win;
      r_owner <= w_win;
      r_cnt   <= {CNT_W{1'b0}};
    end else if ((r_state == BUSY) && !w_finish) begin
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  // Latched controller request; access drops as soon as the transaction ends.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mem_access <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'h0000_0000;
      r_mem_wdata  <= {MEM_W{1'b0}};
      r_mem_be     <= {BE_W{1'b0}};
      r_mem_ext    <= 1'b0;
    end else if (w_start) begin
      r_mem_access <= 1'b1;
      r_mem_addr   <= w_sel_addr;
      r_mem_ext    <= is_ext_addr(w_sel_addr, EXT_BASE);
      if (d_gnt) begin
        r_mem_we    <= d_we;
        r_mem_wdata <= d_wdata;
        r_mem_be    <= d_be;
      end else begin
        r_mem_we    <= 1'b0;
        r_mem_wdata <= {MEM_W{1'b0}};
        r_mem_be    <= {BE_W{1'b1}};
      end
    end else if (w_finish) begin
      r_mem_access <= 1'b0;
    end
  end

  // Response pulses and captured data, routed to the owning port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_i_err    <= 1'b0;
      r_d_err    <= 1'b0;
      r_i_rdata  <= {MEM_W{1'b0}};
      r_d_rdata  <= {MEM_W{1'b0}};
    end else begin
      r_i_rvalid <= w_resp_i;
      r_d_rvalid <= w_resp_d;
      r_i_err    <= w_resp_i && w_timeout;
      r_d_err    <= w_resp_d && w_timeout;
      if (w_resp_i) begin
        r_i_rdata <= w_rdata_cap;
      end
      if (w_resp_d) begin
        r_d_rdata <= w_rdata_cap;
      end
    end
  end

  assign mem_access = r_mem_access;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_be     = r_mem_be;
  assign mem_ext    = r_mem_ext;
  assign i_rvalid   = r_i_rvalid;
  assign i_rdata    = r_i_rdata;
  assign i_err      = r_i_err;
  assign d_rvalid   = r_d_rvalid;
  assign d_rdata    = r_d_rdata;
  assign d_err      = r_d_err;
  assign busy       = (r_state != IDLE);

endmodule
